axi4_lite_arbiter: RTL and testbench
====================================

AXI4_LITE_ARBITER -- requirements
Module: axi4_lite_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width.
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have ACLK  in  1  single clock; all logic on the rising edge.
REQ-004 SHALL have ARESETn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have M0_AR_VALID in 1 / M0_AR_READY out 1 / M0_AR_ADDR in ADDR_W  master 0 (I-cache) read address.
REQ-006 SHALL have M0_R_VALID out 1 / M0_R_READY in 1 / M0_R_DATA out DATA_W  master 0 read data.
REQ-007 SHALL have M1_AR_*, M1_R_*  same directions and widths as REQ-005/006  master 1 (D-cache) read.
REQ-008 SHALL have M1_AW_VALID in 1 / M1_AW_READY out 1 / M1_AW_ADDR in ADDR_W  M1 write address.
REQ-009 SHALL have M1_W_VALID in 1 / M1_W_READY out 1 / M1_W_DATA in DATA_W / M1_W_STRB in DATA_W/8  M1 write data.
REQ-010 SHALL have M1_B_VALID out 1 / M1_B_READY in 1  M1 write response.
REQ-011 SHALL have S_AR_*, S_R_*, S_AW_*, S_W_*, S_B_*  M1 set with directions reversed  shared port to the AXI4-Lite bus.
REQ-012 SHALL have GNT  out 2  one-hot owner: bit0 = M0, bit1 = M1; 0 when idle.

Function
REQ-013 SHALL implement FSM states IDLE, RD_ADDR, RD_DATA, WR_XFER, WR_RESP, with one transaction outstanding on S at a time.
REQ-014 In IDLE, SHALL sample candidates r0=M0_AR_VALID, r1=M1_AR_VALID and w1=M1_AW_VALID, register the decision at the ACLK edge, and assert no S_*_VALID.
REQ-015 Within M1, w1 SHALL win over r1 (read-after-write ordering).
REQ-016 Between M0 and M1, SHALL use round-robin with last-owner register LAST (reset = M0, so M1 wins the first tie); LAST SHALL update on grant.
REQ-017 A read grant SHALL go to RD_ADDR and a write grant to WR_XFER, with GNT set on the same edge.
REQ-018 In RD_ADDR, S_AR_VALID/S_AR_ADDR SHALL come from the owner and the owner's AR_READY SHALL equal S_AR_READY; handshake SHALL go to RD_DATA.
REQ-019 In RD_DATA, S_R_VALID/S_R_DATA SHALL go to the owner and S_R_READY SHALL equal the owner's R_READY; handshake SHALL go to IDLE with GNT=0.
REQ-020 In WR_XFER, AW and W SHALL be forwarded independently; AW_DONE/W_DONE SHALL set on their handshakes and mask that channel's VALID/READY; both done, including in the same cycle, SHALL go to WR_RESP.
REQ-021 In WR_RESP, S_B_VALID SHALL drive M1_B_VALID and M1_B_READY SHALL drive S_B_READY; handshake SHALL go to IDLE and clear the flags.
REQ-022 Non-owner VALID/READY outputs SHALL be 0; S data/addr SHALL be driven from the owner, or 0 when idle.
REQ-023 Latency SHALL be: request in cycle N on an idle bus -> S VALID in N+1; one IDLE cycle between back-to-back transactions.
REQ-024 If the owner drops VALID before handshake, SHALL hold state with no abort (protocol violation by master).
REQ-025 Requests from the non-owner SHALL be held pending until IDLE, with no loss or reorder within a master.

Reset
REQ-026 ARESETn low SHALL immediately force state=IDLE, GNT=0, LAST=M0, AW_DONE=W_DONE=0 and all VALID/READY outputs to 0.
REQ-027 Reset mid-transaction SHALL abandon it with no response delivered to any master.
REQ-028 The first arbitration SHALL occur on the first ACLK edge after release.

Configuration
REQ-029 Macro ARB_FIXED_PRIO_EN: defined SHALL give fixed priority, M1 always wins over M0, LAST removed; undefined SHALL give round-robin per REQ-016.

Verification
REQ-030 M0 read 0x40, S_AR_READY=1, S_R_DATA=0xDEADBEEF two cycles later -> S_AR_VALID one cycle after request, M0_R_DATA=0xDEADBEEF, GNT 01 then 00.
REQ-031 M0 and M1 reads held continuously for 4 transactions after reset -> grant order M1,M0,M1,M0; with ARB_FIXED_PRIO_EN -> M1 only while M1 requests.
REQ-032 M1 write 0x100/0x12345678/STRB 0xF, S_W_READY two cycles before S_AW_READY -> exactly one W and one AW handshake, WR_RESP only after both, one M1_B_VALID.
REQ-033 M1_AW_VALID and M1_AR_VALID in the same cycle -> B handshake completes before S_AR_VALID rises.
REQ-034 ARESETn low during RD_DATA -> all VALID/READY and GNT 0 the same cycle; the next M0 read after release completes normally.

Source files
------------

// File: rtl/axi4_lite_arbiter.sv
// ============================================================================
// axi4_lite_arbiter : two-master (I-cache read, D-cache read/write) to one
// AXI4-Lite slave port. Only one transaction is in flight on the slave side.
// Build option: ARB_FIXED_PRIO_EN (M1 always beats M0, no round-robin state).
// Revision: 1.0
// ============================================================================
`default_nettype none

module axi4_lite_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  // master 0 (I-cache) read
  input  logic                M0_AR_VALID,
  output logic                M0_AR_READY,
  input  logic [ADDR_W-1:0]   M0_AR_ADDR,
  output logic                M0_R_VALID,
  input  logic                M0_R_READY,
  output logic [DATA_W-1:0]   M0_R_DATA,
  // master 1 (D-cache) read
  input  logic                M1_AR_VALID,
  output logic                M1_AR_READY,
  input  logic [ADDR_W-1:0]   M1_AR_ADDR,
  output logic                M1_R_VALID,
  input  logic                M1_R_READY,
  output logic [DATA_W-1:0]   M1_R_DATA,
  // master 1 write
  input  logic                M1_AW_VALID,
  output logic                M1_AW_READY,
  input  logic [ADDR_W-1:0]   M1_AW_ADDR,
  input  logic                M1_W_VALID,
  output logic                M1_W_READY,
  input  logic [DATA_W-1:0]   M1_W_DATA,
  input  logic [DATA_W/8-1:0] M1_W_STRB,
  output logic                M1_B_VALID,
  input  logic                M1_B_READY,
  // shared slave-side port
  output logic                S_AR_VALID,
  input  logic                S_AR_READY,
  output logic [ADDR_W-1:0]   S_AR_ADDR,
  input  logic                S_R_VALID,
  output logic                S_R_READY,
  input  logic [DATA_W-1:0]   S_R_DATA,
  output logic                S_AW_VALID,
  input  logic                S_AW_READY,
  output logic [ADDR_W-1:0]   S_AW_ADDR,
  output logic                S_W_VALID,
  input  logic                S_W_READY,
  output logic [DATA_W-1:0]   S_W_DATA,
  output logic [DATA_W/8-1:0] S_W_STRB,
  input  logic                S_B_VALID,
  output logic                S_B_READY,
  output logic [1:0]          GNT
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_XFER = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t     state_q;
  logic [1:0] gnt_q;
  logic       aw_done_q;
  logic       w_done_q;
`ifndef ARB_FIXED_PRIO_EN
  logic       last_q;   // 0 = M0 owned last, 1 = M1 owned last
`endif

  logic own0, own1;
  logic in_rd_addr, in_rd_data, in_wr_xfer, in_wr_resp;
  logic m1_req, pick_m1_d;
  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

  assign own0       = gnt_q[0];
  assign own1       = gnt_q[1];
  assign in_rd_addr = (state_q == RD_ADDR);
  assign in_rd_data = (state_q == RD_DATA);
  assign in_wr_xfer = (state_q == WR_XFER);
  assign in_wr_resp = (state_q == WR_RESP);
  assign GNT        = gnt_q;

  // M1 competes with either channel; its own write beats its own read later.
  always_comb begin
    m1_req = M1_AW_VALID | M1_AR_VALID;
`ifdef ARB_FIXED_PRIO_EN
    pick_m1_d = m1_req;
`else
    pick_m1_d = m1_req & (~M0_AR_VALID | ~last_q);
`endif
  end

  // read path routing
  assign S_AR_VALID  = in_rd_addr & (own1 ? M1_AR_VALID : M0_AR_VALID);
  assign S_AR_ADDR   = own0 ? M0_AR_ADDR : (own1 ? M1_AR_ADDR : '0);
  assign M0_AR_READY = in_rd_addr & own0 & S_AR_READY;
  assign M1_AR_READY = in_rd_addr & own1 & S_AR_READY;
  assign S_R_READY   = in_rd_data & (own1 ? M1_R_READY : M0_R_READY);
  assign M0_R_VALID  = in_rd_data & own0 & S_R_VALID;
  assign M1_R_VALID  = in_rd_data & own1 & S_R_VALID;
  assign M0_R_DATA   = own0 ? S_R_DATA : '0;
  assign M1_R_DATA   = own1 ? S_R_DATA : '0;

  // write path routing; a finished channel stays masked until the response
  assign S_AW_VALID  = in_wr_xfer & ~aw_done_q & M1_AW_VALID;
  assign M1_AW_READY = in_wr_xfer & ~aw_done_q & S_AW_READY;
  assign S_W_VALID   = in_wr_xfer & ~w_done_q & M1_W_VALID;
  assign M1_W_READY  = in_wr_xfer & ~w_done_q & S_W_READY;
  assign S_AW_ADDR   = own1 ? M1_AW_ADDR : '0;
  assign S_W_DATA    = own1 ? M1_W_DATA : '0;
  assign S_W_STRB    = own1 ? M1_W_STRB : '0;
  assign M1_B_VALID  = in_wr_resp & S_B_VALID;
  assign S_B_READY   = in_wr_resp & M1_B_READY;

  assign ar_hs = S_AR_VALID & S_AR_READY;
  assign r_hs  = S_R_READY & S_R_VALID;
  assign aw_hs = S_AW_VALID & S_AW_READY;
  assign w_hs  = S_W_VALID & S_W_READY;
  assign b_hs  = S_B_READY & S_B_VALID;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      gnt_q     <= 2'b00;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      last_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_m1_d) begin
            gnt_q   <= 2'b10;
            state_q <= M1_AW_VALID ? WR_XFER : RD_ADDR;
`ifndef ARB_FIXED_PRIO_EN
            last_q  <= 1'b1;
`endif
          end else if (M0_AR_VALID) begin
            gnt_q   <= 2'b01;
            state_q <= RD_ADDR;
`ifndef ARB_FIXED_PRIO_EN
            last_q  <= 1'b0;
`endif
          end
        end
        RD_ADDR: begin
          if (ar_hs) state_q <= RD_DATA;
        end
        RD_DATA: begin
          if (r_hs) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
          end
        end
        WR_XFER: begin
          if (aw_hs) aw_done_q <= 1'b1;
          if (w_hs)  w_done_q  <= 1'b1;
          if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) state_q <= WR_RESP;
        end
        WR_RESP: begin
          if (b_hs) begin
            state_q   <= IDLE;
            gnt_q     <= 2'b00;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 2'b00;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi4_lite_arbiter.sv
// Directed scoreboard bench for axi4_lite_arbiter: reads, round-robin order,
// split write handshakes, write-before-read ordering and mid-transfer reset.
`default_nettype none

module tb_axi4_lite_arbiter;
  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        M0_AR_VALID, M0_AR_READY, M0_R_VALID, M0_R_READY;
  logic [31:0] M0_AR_ADDR, M0_R_DATA;
  logic        M1_AR_VALID, M1_AR_READY, M1_R_VALID, M1_R_READY;
  logic [31:0] M1_AR_ADDR, M1_R_DATA;
  logic        M1_AW_VALID, M1_AW_READY, M1_W_VALID, M1_W_READY, M1_B_VALID, M1_B_READY;
  logic [31:0] M1_AW_ADDR, M1_W_DATA;
  logic [3:0]  M1_W_STRB;
  logic        S_AR_VALID, S_AR_READY, S_R_VALID, S_R_READY;
  logic [31:0] S_AR_ADDR, S_R_DATA;
  logic        S_AW_VALID, S_AW_READY, S_W_VALID, S_W_READY, S_B_VALID, S_B_READY;
  logic [31:0] S_AW_ADDR, S_W_DATA;
  logic [3:0]  S_W_STRB;
  logic [1:0]  GNT;

  axi4_lite_arbiter #(.DATA_W(32), .ADDR_W(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .M0_AR_VALID(M0_AR_VALID), .M0_AR_READY(M0_AR_READY), .M0_AR_ADDR(M0_AR_ADDR),
    .M0_R_VALID(M0_R_VALID), .M0_R_READY(M0_R_READY), .M0_R_DATA(M0_R_DATA),
    .M1_AR_VALID(M1_AR_VALID), .M1_AR_READY(M1_AR_READY), .M1_AR_ADDR(M1_AR_ADDR),
    .M1_R_VALID(M1_R_VALID), .M1_R_READY(M1_R_READY), .M1_R_DATA(M1_R_DATA),
    .M1_AW_VALID(M1_AW_VALID), .M1_AW_READY(M1_AW_READY), .M1_AW_ADDR(M1_AW_ADDR),
    .M1_W_VALID(M1_W_VALID), .M1_W_READY(M1_W_READY), .M1_W_DATA(M1_W_DATA),
    .M1_W_STRB(M1_W_STRB), .M1_B_VALID(M1_B_VALID), .M1_B_READY(M1_B_READY),
    .S_AR_VALID(S_AR_VALID), .S_AR_READY(S_AR_READY), .S_AR_ADDR(S_AR_ADDR),
    .S_R_VALID(S_R_VALID), .S_R_READY(S_R_READY), .S_R_DATA(S_R_DATA),
    .S_AW_VALID(S_AW_VALID), .S_AW_READY(S_AW_READY), .S_AW_ADDR(S_AW_ADDR),
    .S_W_VALID(S_W_VALID), .S_W_READY(S_W_READY), .S_W_DATA(S_W_DATA),
    .S_W_STRB(S_W_STRB), .S_B_VALID(S_B_VALID), .S_B_READY(S_B_READY),
    .GNT(GNT)
  );

  always #5 ACLK = ~ACLK;

  int          checks = 0;
  int          errors = 0;
  logic [1:0]  exp_gnt_q[$];
  logic [31:0] exp_rdata_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] vr_all();
    return {M0_AR_READY, M0_R_VALID, M1_AR_READY, M1_R_VALID, M1_AW_READY, M1_W_READY,
            M1_B_VALID, S_AR_VALID, S_R_READY, S_AW_VALID, S_W_VALID, S_B_READY};
  endfunction

  task automatic clear_inputs();
    M0_AR_VALID = 0; M0_AR_ADDR = 0; M0_R_READY = 0;
    M1_AR_VALID = 0; M1_AR_ADDR = 0; M1_R_READY = 0;
    M1_AW_VALID = 0; M1_AW_ADDR = 0; M1_W_VALID = 0; M1_W_DATA = 0; M1_W_STRB = 0;
    M1_B_READY = 0;
    S_AR_READY = 0; S_R_VALID = 0; S_R_DATA = 0; S_AW_READY = 0; S_W_READY = 0;
    S_B_VALID = 0;
  endtask

  initial begin
    logic [1:0] e;
    logic [1:0] prev;
    int aw_n, w_n, b_n, bv_n;
    bit b_seen, order_bad, done, got;
    bit p_aw, p_w, p_ar, p_b, p_r;

    // ---------------- reset state, slave side pretending to be ready
    clear_inputs();
    S_AR_READY = 1; S_R_VALID = 1; S_AW_READY = 1; S_W_READY = 1; S_B_VALID = 1;
    M0_R_READY = 1; M1_R_READY = 1; M1_B_READY = 1;
    #3;
    chk("reset_gnt", GNT, 2'b00);
    chk("reset_vr", vr_all(), 12'h000);
    clear_inputs();
    @(posedge ACLK); #1 ARESETn = 1;

    // ---------------- M0 read 0x40 -> 0xDEADBEEF
    @(posedge ACLK); #1;
    M0_AR_VALID = 1; M0_AR_ADDR = 32'h40; S_AR_READY = 1; M0_R_READY = 1;
    exp_gnt_q.push_back(2'b01);
    @(negedge ACLK);
    chk("t1_idle_ar_valid", S_AR_VALID, 1'b0);
    chk("t1_idle_gnt", GNT, 2'b00);
    @(posedge ACLK); #1;
    @(negedge ACLK);
    chk("t1_gnt", GNT, exp_gnt_q.pop_front());
    chk("t1_ar_valid", S_AR_VALID, 1'b1);
    chk("t1_ar_addr", S_AR_ADDR, 32'h40);
    chk("t1_m0_ar_ready", M0_AR_READY, 1'b1);
    @(posedge ACLK); #1;
    M0_AR_VALID = 0; S_AR_READY = 0;
    S_R_VALID = 1; S_R_DATA = 32'hDEADBEEF; exp_rdata_q.push_back(32'hDEADBEEF);
    @(negedge ACLK);
    chk("t1_m0_r_valid", M0_R_VALID, 1'b1);
    chk("t1_m0_r_data", M0_R_DATA, exp_rdata_q.pop_front());
    chk("t1_m1_r_valid", M1_R_VALID, 1'b0);
    chk("t1_s_r_ready", S_R_READY, 1'b1);
    @(posedge ACLK); #1;
    S_R_VALID = 0; S_R_DATA = 0;
    @(negedge ACLK);
    chk("t1_gnt_end", GNT, 2'b00);
    chk("t1_vr_end", vr_all(), 12'h000);

    // ---------------- both masters reading continuously after reset
    @(posedge ACLK); #1 ARESETn = 0;
    @(posedge ACLK); #1 ARESETn = 1;
    M0_AR_VALID = 1; M0_AR_ADDR = 32'h1000; M1_AR_VALID = 1; M1_AR_ADDR = 32'h2000;
    S_AR_READY = 1; S_R_VALID = 1; M0_R_READY = 1; M1_R_READY = 1;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) exp_gnt_q.push_back(2'b10);
`else
    exp_gnt_q.push_back(2'b10); exp_gnt_q.push_back(2'b01);
    exp_gnt_q.push_back(2'b10); exp_gnt_q.push_back(2'b01);
`endif
    for (int t = 0; t < 4; t++) begin
      got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
        @(negedge ACLK);
        if (GNT != 2'b00) got = 1;
      end
      chk("t2_grant_seen", got, 1'b1);
      e = exp_gnt_q.pop_front();
      chk("t2_gnt_order", GNT, e);
      chk("t2_ar_addr", S_AR_ADDR, (e == 2'b01) ? 32'h1000 : 32'h2000);
      got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
        @(negedge ACLK);
        if (GNT == 2'b00) got = 1;
      end
      chk("t2_release_seen", got, 1'b1);
    end
    clear_inputs();

    // ---------------- M1 write, W ready two cycles before AW ready
    @(posedge ACLK); #1;
    M1_AW_VALID = 1; M1_AW_ADDR = 32'h100; M1_W_VALID = 1; M1_W_DATA = 32'h12345678;
    M1_W_STRB = 4'hF; M1_B_READY = 1;
    exp_gnt_q.push_back(2'b10);
    aw_n = 0; w_n = 0; b_n = 0; bv_n = 0;
    for (int c = 1; c <= 5; c++) begin
      @(posedge ACLK); #1;
      S_W_READY  = (c == 1 || c == 2);
      S_AW_READY = (c == 3);
      S_B_VALID  = (c >= 2);
      @(negedge ACLK);
      if (S_AW_VALID && S_AW_READY) aw_n++;
      if (S_W_VALID && S_W_READY) w_n++;
      if (M1_B_VALID) bv_n++;
      if (S_B_VALID && S_B_READY) b_n++;
      if (c == 1) begin
        chk("t3_gnt", GNT, exp_gnt_q.pop_front());
        chk("t3_aw_w_valid", {S_AW_VALID, S_W_VALID}, 2'b11);
        chk("t3_aw_addr", S_AW_ADDR, 32'h100);
        chk("t3_w_data", S_W_DATA, 32'h12345678);
        chk("t3_w_strb", S_W_STRB, 4'hF);
      end
      if (c == 2) chk("t3_w_masked", {S_W_VALID, M1_W_READY, S_AW_VALID}, 3'b001);
      if (c == 2 || c == 3) chk("t3_no_early_b", {M1_B_VALID, S_B_READY}, 2'b00);
      if (c == 4) begin
        chk("t3_resp", {M1_B_VALID, S_B_READY, S_AW_VALID, S_W_VALID}, 4'b1100);
        M1_AW_VALID = 0; M1_W_VALID = 0;
      end
      if (c == 5) chk("t3_idle", {GNT, M1_B_VALID}, 3'b000);
    end
    chk("t3_aw_count", aw_n, 1);
    chk("t3_w_count", w_n, 1);
    chk("t3_b_count", b_n, 1);
    chk("t3_bvalid_count", bv_n, 1);
    clear_inputs();

    // ---------------- M1 AW and AR together: write completes first
    @(posedge ACLK); #1;
    M1_AW_VALID = 1; M1_AW_ADDR = 32'h300; M1_W_VALID = 1; M1_W_DATA = 32'hA5A5A5A5;
    M1_W_STRB = 4'h3; M1_AR_VALID = 1; M1_AR_ADDR = 32'h200;
    M1_B_READY = 1; M1_R_READY = 1;
    S_AW_READY = 1; S_W_READY = 1; S_AR_READY = 1; S_B_VALID = 1;
    S_R_VALID = 1; S_R_DATA = 32'hCAFEF00D;
    exp_gnt_q.push_back(2'b10); exp_gnt_q.push_back(2'b10);
    exp_rdata_q.push_back(32'hCAFEF00D);
    b_seen = 0; order_bad = 0; done = 0; prev = 2'b00;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge ACLK);
      if (GNT != 2'b00 && prev == 2'b00) chk("t4_gnt", GNT, exp_gnt_q.pop_front());
      prev = GNT;
      if (S_AR_VALID && !b_seen) order_bad = 1;
      p_aw = S_AW_VALID && S_AW_READY;
      p_w  = S_W_VALID && S_W_READY;
      p_ar = S_AR_VALID && S_AR_READY;
      p_b  = S_B_VALID && S_B_READY;
      p_r  = M1_R_VALID && M1_R_READY;
      if (p_ar) chk("t4_ar_addr", S_AR_ADDR, 32'h200);
      if (p_r) begin
        chk("t4_r_data", M1_R_DATA, exp_rdata_q.pop_front());
        done = 1;
      end
      @(posedge ACLK); #1;
      if (p_aw) M1_AW_VALID = 0;
      if (p_w)  M1_W_VALID = 0;
      if (p_ar) M1_AR_VALID = 0;
      if (p_r)  S_R_VALID = 0;
      if (p_b) begin
        S_B_VALID = 0;
        b_seen = 1;
      end
    end
    chk("t4_read_done", done, 1'b1);
    chk("t4_b_seen", b_seen, 1'b1);
    chk("t4_b_before_ar", order_bad, 1'b0);
    clear_inputs();

    // ---------------- reset during RD_DATA, then a normal M0 read
    @(posedge ACLK); #1;
    M0_AR_VALID = 1; M0_AR_ADDR = 32'h80; S_AR_READY = 1; M0_R_READY = 1;
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    M0_AR_VALID = 0; S_AR_READY = 0; S_R_VALID = 1; S_R_DATA = 32'h11111111;
    #1 chk("t5_in_rd_data", M0_R_VALID, 1'b1);
    #1 ARESETn = 0;
    #1;
    chk("t5_rst_gnt", GNT, 2'b00);
    chk("t5_rst_vr", vr_all(), 12'h000);
    @(posedge ACLK); #1 ARESETn = 1;
    @(negedge ACLK);
    chk("t5_after_rel", {GNT, M0_R_VALID}, 3'b000);
    @(posedge ACLK); #1;
    M0_AR_VALID = 1; M0_AR_ADDR = 32'h84; S_AR_READY = 1; M0_R_READY = 1;
    S_R_VALID = 1; S_R_DATA = 32'h5A5AA5A5;
    exp_gnt_q.push_back(2'b01); exp_rdata_q.push_back(32'h5A5AA5A5);
    got = 0; prev = 2'b00;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge ACLK);
      if (GNT != 2'b00 && prev == 2'b00) chk("t5_gnt", GNT, exp_gnt_q.pop_front());
      prev = GNT;
      p_ar = S_AR_VALID && S_AR_READY;
      if (M0_R_VALID && M0_R_READY) begin
        chk("t5_r_data", M0_R_DATA, exp_rdata_q.pop_front());
        got = 1;
      end
      @(posedge ACLK); #1;
      if (p_ar) M0_AR_VALID = 0;
      if (got) S_R_VALID = 0;
    end
    chk("t5_read_done", got, 1'b1);
    @(negedge ACLK);
    chk("t5_gnt_end", GNT, 2'b00);
    chk("scoreboard_empty", exp_gnt_q.size() + exp_rdata_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
